// File: rtl/aes_engine_key_generator.sv
// AES-128 key-expansion front end: latches the cipher key on engine_start,
// derives one round key per clock, then raises transformer_start and holds
// the 11 round keys stable until the round transformer reports done.
module aes_engine_key_generator (
  input  logic         clk,
  input  logic         rst_,
  input  logic [127:0] key_in,
  input  logic         engine_start,
  input  logic         transformer_done,
  output logic         transformer_start,
  output logic [127:0] round0_key,
  output logic [127:0] round1_key,
  output logic [127:0] round2_key,
  output logic [127:0] round3_key,
  output logic [127:0] round4_key,
  output logic [127:0] round5_key,
  output logic [127:0] round6_key,
  output logic [127:0] round7_key,
  output logic [127:0] round8_key,
  output logic [127:0] round9_key,
  output logic [127:0] round10_key
);

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  // S-box ROM, row 0 in the most significant bits so byte x sits at {~x,3'b000}
  localparam logic [2047:0] SBOX_ROM = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  state_t         state, state_next;
  logic [3:0]     rcount;
  logic [127:0]   rk [0:10];
  logic [127:0]   prev_key;
  logic [127:0]   next_key;
  logic [31:0]    rot_word;
  logic [31:0]    sub_word;
  logic [31:0]    temp_word;
  logic [7:0]     rcon;
  logic [31:0]    n0, n1, n2, n3;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_ROM[{~x, 3'b000} +: 8];
  endfunction

  // Next-state decode for the IDLE -> EXPAND -> READY -> IDLE sequence
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (engine_start) state_next = EXPAND;
      EXPAND:  if (rcount == 4'd10) state_next = READY;
      READY:   if (transformer_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Pick the previously stored round key and the round constant for this step
  always_comb begin
    prev_key = '0;
    for (int i = 0; i < 10; i++) begin
      if (rcount == 4'(i + 1)) prev_key = rk[i];
    end
    case (rcount)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  // One key-schedule step: RotWord, SubWord, Rcon, then the chained word XORs
  always_comb begin
    rot_word  = {prev_key[23:0], prev_key[31:24]};
    sub_word  = {sbox(rot_word[31:24]), sbox(rot_word[23:16]),
                 sbox(rot_word[15:8]),  sbox(rot_word[7:0])};
    temp_word = sub_word ^ {rcon, 24'h000000};
    n0        = prev_key[127:96] ^ temp_word;
    n1        = n0 ^ prev_key[95:64];
    n2        = n1 ^ prev_key[63:32];
    n3        = n2 ^ prev_key[31:0];
    next_key  = {n0, n1, n2, n3};
  end

  // State, round counter and transformer_start (high exactly while in READY)
  always_ff @(posedge clk) begin
    if (rst_) begin
      state             <= IDLE;
      rcount            <= 4'd0;
      transformer_start <= 1'b0;
    end else begin
      state             <= state_next;
      transformer_start <= (state_next == READY);
      if (state == IDLE && engine_start) rcount <= 4'd1;
      else if (state == EXPAND) rcount <= (rcount == 4'd10) ? 4'd0 : rcount + 4'd1;
    end
  end

  // Round key storage: load on an accepted start, fill one slot per EXPAND cycle
  always_ff @(posedge clk) begin
    if (rst_) begin
      for (int i = 0; i <= 10; i++) rk[i] <= '0;
    end else if (state == IDLE && engine_start) begin
      rk[0] <= key_in;
      for (int i = 1; i <= 10; i++) rk[i] <= '0;
    end else if (state == EXPAND) begin
      for (int i = 1; i <= 10; i++) begin
        if (rcount == 4'(i)) rk[i] <= next_key;
      end
    end
  end

  assign round0_key  = rk[0];
  assign round1_key  = rk[1];
  assign round2_key  = rk[2];
  assign round3_key  = rk[3];
  assign round4_key  = rk[4];
  assign round5_key  = rk[5];
  assign round6_key  = rk[6];
  assign round7_key  = rk[7];
  assign round8_key  = rk[8];
  assign round9_key  = rk[9];
  assign round10_key = rk[10];

endmodule

// File: tb/tb_aes_engine_key_generator.sv
// Testbench for aes_engine_key_generator: known-answer table, randomized keys
// against a GF(2^8)-derived key-schedule model, handshake, back-to-back and
// mid-expansion reset sequences.
module tb_aes_engine_key_generator;

  logic         clk = 1'b0;
  logic         rst_;
  logic [127:0] key_in;
  logic         engine_start;
  logic         transformer_done;
  logic         transformer_start;
  logic [127:0] dut_rk [0:10];

  int checks = 0;
  int fails  = 0;

  logic [7:0]   sbox_model [0:255];
  logic [127:0] model_rk [0:10];

  typedef struct {
    logic [127:0] key;
    int           idx;
    logic [127:0] expected;
  } vec_t;
  vec_t vecs [0:4];

  aes_engine_key_generator dut (
    .clk               (clk),
    .rst_              (rst_),
    .key_in            (key_in),
    .engine_start      (engine_start),
    .transformer_done  (transformer_done),
    .transformer_start (transformer_start),
    .round0_key        (dut_rk[0]),
    .round1_key        (dut_rk[1]),
    .round2_key        (dut_rk[2]),
    .round3_key        (dut_rk[3]),
    .round4_key        (dut_rk[4]),
    .round5_key        (dut_rk[5]),
    .round6_key        (dut_rk[6]),
    .round7_key        (dut_rk[7]),
    .round8_key        (dut_rk[8]),
    .round9_key        (dut_rk[9]),
    .round10_key       (dut_rk[10])
  );

  // Free-running clock
  always #5 clk = ~clk;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map
  task automatic buildSbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_model[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^
                      rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Word-array key schedule w[0..43], grouped into 11 round keys
  task automatic modelExpand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] temp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = {temp[23:0], temp[31:24]};
        temp = {sbox_model[temp[31:24]], sbox_model[temp[23:16]],
                sbox_model[temp[15:8]], sbox_model[temp[7:0]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r <= 10; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] randKey();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic d,
                               input logic [127:0] k);
    rst_             = r;
    engine_start     = s;
    transformer_done = d;
    key_in           = k;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act,
                             input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic checkAllKeys(input string tag);
    for (int i = 0; i <= 10; i++)
      checkOutput($sformatf("%s_round%0d", tag, i), dut_rk[i], model_rk[i]);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_tstart"}, {127'b0, transformer_start}, 128'd0);
    for (int i = 0; i <= 10; i++)
      checkOutput($sformatf("%s_zero%0d", tag, i), dut_rk[i], 128'd0);
  endtask

  // Accepts a start for 'key' (model must be loaded), checks per-cycle timing
  task automatic startExpansion(input logic [127:0] key);
    applyStimulus(1'b0, 1'b1, 1'b0, key);
    tick();
    checkOutput("e0_round0", dut_rk[0], key);
    checkOutput("e0_tstart", {127'b0, transformer_start}, 128'd0);
    for (int j = 1; j <= 9; j++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, randKey());
      tick();
      checkOutput($sformatf("step_round%0d", j), dut_rk[j], model_rk[j]);
    end
    checkOutput("e9_tstart", {127'b0, transformer_start}, 128'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, randKey());
    tick();
    checkOutput("e10_tstart", {127'b0, transformer_start}, 128'd1);
    checkOutput("e10_round10", dut_rk[10], model_rk[10]);
  endtask

  // Holds READY, then completes the done handshake and confirms keys persist
  task automatic finishHandshake();
    for (int j = 0; j < 3; j++) begin
      tick();
      checkOutput("hold_tstart", {127'b0, transformer_start}, 128'd1);
      checkOutput("hold_round10", dut_rk[10], model_rk[10]);
    end
    transformer_done = 1'b1;
    tick();
    checkOutput("done_tstart", {127'b0, transformer_start}, 128'd0);
    transformer_done = 1'b0;
    tick();
    checkOutput("idle_tstart", {127'b0, transformer_start}, 128'd0);
    checkAllKeys("idle");
  endtask

  initial begin
    logic [127:0] k;
    buildSbox();

    vecs[0] = '{128'h2475A2B33475568831E2120013AA5487, 0, 128'h2475A2B33475568831E2120013AA5487};
    vecs[1] = '{128'h2475A2B33475568831E2120013AA5487, 1, 128'h8955B5CEBD20E3468CC2F1469F68A5C1};
    vecs[2] = '{128'h2B7E151628AED2A6ABF7158809CF4F3C, 1, 128'hA0FAFE1788542CB123A339392A6C7605};
    vecs[3] = '{128'h2B7E151628AED2A6ABF7158809CF4F3C, 2, 128'hF2C295F27A96B9435935807A7359F67F};
    vecs[4] = '{128'h2B7E151628AED2A6ABF7158809CF4F3C, 10, 128'hD014F9A8C9EE2589E13F0CC8B6630CA6};

    // Reset held two edges with start asserted: nothing may load
    applyStimulus(1'b1, 1'b1, 1'b0, randKey());
    tick();
    tick();
    checkAllZero("reset");
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    tick();
    checkAllZero("post_reset");

    // Known-answer table
    for (int i = 0; i < 5; i++) begin
      modelExpand(vecs[i].key);
      startExpansion(vecs[i].key);
      checkOutput($sformatf("kat%0d_round%0d", i, vecs[i].idx),
                  dut_rk[vecs[i].idx], vecs[i].expected);
      finishHandshake();
    end

    // Randomized keys against the model
    for (int i = 0; i < 6; i++) begin
      k = randKey();
      modelExpand(k);
      startExpansion(k);
      checkAllKeys("rand");
      finishHandshake();
    end

    // done and start both held: one-cycle transformer_start every 12 cycles
    k = randKey();
    modelExpand(k);
    applyStimulus(1'b0, 1'b1, 1'b1, k);
    tick();
    for (int cyc = 1; cyc <= 35; cyc++) begin
      tick();
      checkOutput($sformatf("b2b_tstart_c%0d", cyc), {127'b0, transformer_start},
                  (cyc % 12 == 10) ? 128'd1 : 128'd0);
      if (cyc % 12 == 10) checkAllKeys("b2b");
    end
    applyStimulus(1'b0, 1'b0, 1'b0, k);
    tick();
    checkOutput("b2b_idle_round0", dut_rk[0], model_rk[0]);

    // Reset in the middle of expansion, then a fresh expansion
    k = randKey();
    modelExpand(k);
    applyStimulus(1'b0, 1'b1, 1'b0, k);
    tick();
    engine_start = 1'b0;
    for (int j = 0; j < 5; j++) tick();
    checkOutput("mid_round5", dut_rk[5], model_rk[5]);
    rst_ = 1'b1;
    tick();
    checkAllZero("mid_reset");
    rst_ = 1'b0;
    tick();
    checkAllZero("mid_reset_idle");
    k = randKey();
    modelExpand(k);
    startExpansion(k);
    checkAllKeys("after_reset");
    finishHandshake();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
